blink_select_controller: RTL and testbench
==========================================

// Module: blink_select_controller
// PURPOSE
//   Sequencer for the 1-to-4 LED blink demux. Generates the blink toggle, debounces
//   the two select switches and drives the demux select so the blink moves between
//   LEDs glitch-free: the select changes only while the toggle is low, and the
//   half-period counter restarts on every handover.
//   Sits between the board switch pins and the demux select/data inputs.
// PARAMETERS
//   CLKS_PER_HALF_PERIOD  12_500_000  clocks per toggle half-period (1 Hz blink at 25 MHz)
//   DEBOUNCE_LIMIT        250_000     consecutive mismatching clocks before switch accepted (10 ms)
// PORTS
//   i_Clk       in   1  system clock, single clock domain
//   i_Rst       in   1  synchronous, active-high reset
//   i_Switch_1  in   1  raw switch, async, bouncy; select bit 0
//   i_Switch_2  in   1  raw switch, async, bouncy; select bit 1
//   i_Enable    in   1  1 = blink, 0 = hold toggle low
//   o_Toggle    out  1  blink data to demux
//   o_Sel       out  2  demux select {sw2,sw1}: 00->LED1 01->LED2 10->LED3 11->LED4
//   o_Busy      out  1  high while a select change is pending (DRAIN/HANDOVER)
// BEHAVIOUR
//   Reset: o_Toggle=0, o_Sel=2'b00, o_Busy=0, state=IDLE, debounced switches=0,
//     all counters=0, synchronizer flops=0. Reset wins over every other event.
//   Sync: 2-FF synchronizer per switch.
//   Debounce (per switch): counter++ each cycle synced!=debounced; any cycle
//     synced==debounced clears counter; when counter==DEBOUNCE_LIMIT-1 and still
//     mismatched, debounced<=synced, counter<=0 (accept after DEBOUNCE_LIMIT cycles).
//   req = {db_sw2, db_sw1}.
//   Half-period counter: 0..CLKS_PER_HALF_PERIOD-1, runs only in BLINK/DRAIN;
//     tick = (count==CLKS_PER_HALF_PERIOD-1), count wraps to 0 on tick.
//   FSM:
//     IDLE: o_Toggle=0, count=0, o_Busy=0; o_Sel<=req every cycle (no drain needed);
//       i_Enable=1 -> BLINK.
//     BLINK: on tick o_Toggle<=~o_Toggle. If req!=o_Sel -> DRAIN (tick toggling in
//       the same cycle still applies).
//     DRAIN: o_Busy=1. If o_Toggle==0 -> HANDOVER next cycle. Else wait; on tick
//       o_Toggle<=0 -> HANDOVER. Toggle never rises in DRAIN.
//     HANDOVER (1 cycle): o_Busy=1; o_Sel<=req (latest value, even if changed
//       during DRAIN); count<=0; o_Toggle stays 0 -> BLINK. New LED always starts
//       with a full off half-period.
//     i_Enable=0 in BLINK/DRAIN/HANDOVER -> IDLE next cycle, o_Toggle<=0, count<=0.
//   req returning to o_Sel during DRAIN: handover still completes (o_Sel rewritten
//     with same value, counter restarts).
//   Latency switch->o_Sel: 2 (sync) + DEBOUNCE_LIMIT + drain wait
//     (0..CLKS_PER_HALF_PERIOD) + 1 (HANDOVER); in IDLE: 2 + DEBOUNCE_LIMIT + 1.
//   Outputs are registered; no combinational path from inputs to outputs.
// TESTING  (CLKS_PER_HALF_PERIOD=4, DEBOUNCE_LIMIT=3)
//   1 Reset then i_Enable=1, switches 0 -> o_Sel=00, o_Toggle 0 x4 clocks then 1 x4, repeating; o_Busy=0.
//   2 i_Switch_1 glitch high for 2 clocks -> o_Sel stays 00, o_Busy never asserts.
//   3 i_Switch_1=1 held while o_Toggle=1 -> after 2+3 clocks o_Busy=1, o_Toggle falls at
//     next tick, next clock o_Sel=01, then o_Toggle=0 for exactly 4 clocks before rising.
//   4 Switch change accepted while o_Toggle=0 -> DRAIN 1 clock, HANDOVER, o_Sel updates,
//     counter restarts (off period extended to full 4 clocks).
//   5 i_Enable=0 with o_Toggle=1 -> o_Toggle=0 next clock; i_Switch_2=1 while disabled ->
//     o_Sel=10 after 2+3+1 clocks, o_Busy stays 0.
//   6 i_Rst=1 during DRAIN -> next edge o_Toggle=0, o_Sel=00, o_Busy=0; switch state
//     re-debounced from 0 after release.

Source files
------------

// File: rtl/blink_select_controller.sv
// rtl/blink_select_controller.sv - blink toggle generator and glitch-free demux select sequencer
//
// Purpose: produces the LED blink toggle and the 1-to-4 demux select. Both
//   switches are synchronized and debounced. The select only changes while
//   the toggle is low, and each newly selected LED starts with a full off
//   half-period.
// Ports:
//   i_Clk       in   1  system clock
//   i_Rst       in   1  synchronous, active-high reset
//   i_Switch_1  in   1  raw switch, select bit 0
//   i_Switch_2  in   1  raw switch, select bit 1
//   i_Enable    in   1  1 = blink, 0 = hold toggle low
//   o_Toggle    out  1  blink data to demux
//   o_Sel       out  2  demux select {sw2,sw1}
//   o_Busy      out  1  select change pending (DRAIN/HANDOVER)

module blink_select_controller #(
  parameter int CLKS_PER_HALF_PERIOD = 12_500_000,
  parameter int DEBOUNCE_LIMIT       = 250_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Enable,
  output logic       o_Toggle,
  output logic [1:0] o_Sel,
  output logic       o_Busy
);

  localparam int CW = (CLKS_PER_HALF_PERIOD > 1) ? $clog2(CLKS_PER_HALF_PERIOD) : 1;
  localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] HP_LAST = CW'(CLKS_PER_HALF_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BLINK    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HANDOVER = 2'd3
  } state_t;

  // Switch synchronizers and debouncers; bit 0 = switch 1, bit 1 = switch 2.
  logic [1:0]         sw_meta;
  logic [1:0]         sw_sync;
  logic [1:0]         sw_db;
  logic [1:0][DW-1:0] db_cnt;
  logic [1:0]         req;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hp_cnt;
  logic [CW-1:0] hp_cnt_nxt;
  logic          tick;
  logic          toggle_nxt;
  logic [1:0]    sel_nxt;
  logic          busy_nxt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_db   <= '0;
      db_cnt  <= '0;
    end else begin
      sw_meta <= {i_Switch_2, i_Switch_1};
      sw_sync <= sw_meta;
      for (int i = 0; i < 2; i++) begin
        // Any agreeing cycle restarts the count, so only a steady level is accepted.
        if (sw_sync[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_db[i]  <= sw_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign req  = sw_db;
  assign tick = (hp_cnt == HP_LAST);

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_Enable) state_nxt = ST_BLINK;
      end
      ST_BLINK: begin
        if (!i_Enable)          state_nxt = ST_IDLE;
        else if (req != o_Sel)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_Enable)                state_nxt = ST_IDLE;
        else if (!o_Toggle || tick)   state_nxt = ST_HANDOVER;
      end
      ST_HANDOVER: begin
        if (!i_Enable) state_nxt = ST_IDLE;
        else           state_nxt = ST_BLINK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the half-period counter
  always_comb begin
    toggle_nxt = o_Toggle;
    sel_nxt    = o_Sel;
    hp_cnt_nxt = hp_cnt;
    case (state)
      ST_IDLE: begin
        // Toggle is already low, so the select can follow the switches directly.
        toggle_nxt = 1'b0;
        hp_cnt_nxt = '0;
        sel_nxt    = req;
      end
      ST_BLINK: begin
        hp_cnt_nxt = tick ? '0 : hp_cnt + 1'b1;
        if (tick) toggle_nxt = ~o_Toggle;
      end
      ST_DRAIN: begin
        // Only the falling half of a tick is honoured; the toggle never rises here.
        hp_cnt_nxt = tick ? '0 : hp_cnt + 1'b1;
        if (tick) toggle_nxt = 1'b0;
      end
      ST_HANDOVER: begin
        // Latest request wins, and the counter restarts so the new LED gets a full off period.
        sel_nxt    = req;
        hp_cnt_nxt = '0;
        toggle_nxt = 1'b0;
      end
      default: begin
        toggle_nxt = 1'b0;
        hp_cnt_nxt = '0;
      end
    endcase
    if (state != ST_IDLE && !i_Enable) begin
      toggle_nxt = 1'b0;
      hp_cnt_nxt = '0;
    end
    busy_nxt = (state_nxt == ST_DRAIN) || (state_nxt == ST_HANDOVER);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Toggle <= 1'b0;
      o_Sel    <= 2'b00;
      o_Busy   <= 1'b0;
      hp_cnt   <= '0;
    end else begin
      o_Toggle <= toggle_nxt;
      o_Sel    <= sel_nxt;
      o_Busy   <= busy_nxt;
      hp_cnt   <= hp_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_blink_select_controller.sv
// tb/tb_blink_select_controller.sv - directed self-checking bench for blink_select_controller

module tb_blink_select_controller;

  localparam int HP = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw1;
  logic       sw2;
  logic       en;
  logic       tog;
  logic [1:0] sel;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n;
  logic busy_seen;

  logic       h_tog  [0:15];
  logic [1:0] h_sel  [0:15];
  logic       h_busy [0:15];

  always #5 clk = ~clk;

  blink_select_controller #(
    .CLKS_PER_HALF_PERIOD(HP),
    .DEBOUNCE_LIMIT(DB)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .i_Switch_1(sw1),
    .i_Switch_2(sw2),
    .i_Enable(en),
    .o_Toggle(tog),
    .o_Sel(sel),
    .o_Busy(busy)
  );

  always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  task automatic wait_tog(input logic v, input int bound, output int cyc);
    cyc = 0;
    while (tog !== v && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (tog !== v) begin
      check_eq("wait_tog_timeout", tog, v);
      cyc = -1;
    end
  endtask

  // h_*[j] holds the outputs j clocks after the current negedge.
  task automatic record(input int len);
    for (int j = 0; j < len; j++) begin
      if (j > 0) @(negedge clk);
      h_tog[j]  = tog;
      h_sel[j]  = sel;
      h_busy[j] = busy;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sw1 = 1'b0; sw2 = 1'b0; busy_seen = 1'b0;
    step(3);
    check_eq("rst_toggle", tog, 0);
    check_eq("rst_sel", sel, 2'b00);
    check_eq("rst_busy", busy, 0);

    // 1: plain blinking, 4 clocks per half-period
    rst = 1'b0; en = 1'b1; busy_seen = 1'b0;
    wait_tog(1'b1, 20, n); check_eq("t1_first_off", n, 5);
    wait_tog(1'b0, 20, n); check_eq("t1_on", n, 4);
    wait_tog(1'b1, 20, n); check_eq("t1_off", n, 4);
    wait_tog(1'b0, 20, n); check_eq("t1_on2", n, 4);
    check_eq("t1_sel", sel, 2'b00);
    check_eq("t1_busy_never", busy_seen, 0);

    // 2: two-clock glitch is rejected
    sw1 = 1'b1; step(2); sw1 = 1'b0; step(10);
    check_eq("t2_sel", sel, 2'b00);
    check_eq("t2_busy_never", busy_seen, 0);

    // 3: switch change while the toggle is high drains first
    wait_tog(1'b1, 20, n); wait_tog(1'b0, 20, n);
    step(1); sw1 = 1'b1;
    record(14);
    check_eq("t3_busy5", h_busy[5], 0);
    check_eq("t3_busy6", h_busy[6], 1);
    check_eq("t3_busy7", h_busy[7], 1);
    check_eq("t3_busy8", h_busy[8], 0);
    check_eq("t3_tog6", h_tog[6], 1);
    check_eq("t3_tog7", h_tog[7], 0);
    check_eq("t3_sel7", h_sel[7], 2'b00);
    check_eq("t3_sel8", h_sel[8], 2'b01);
    check_eq("t3_tog11", h_tog[11], 0);
    check_eq("t3_tog12", h_tog[12], 1);

    // 4: switch change accepted while the toggle is low, off period extended
    wait_tog(1'b0, 20, n); wait_tog(1'b1, 20, n);
    sw1 = 1'b0;
    record(14);
    check_eq("t4_tog3", h_tog[3], 1);
    check_eq("t4_tog4", h_tog[4], 0);
    check_eq("t4_busy5", h_busy[5], 0);
    check_eq("t4_busy6", h_busy[6], 1);
    check_eq("t4_busy7", h_busy[7], 1);
    check_eq("t4_busy8", h_busy[8], 0);
    check_eq("t4_sel7", h_sel[7], 2'b01);
    check_eq("t4_sel8", h_sel[8], 2'b00);
    check_eq("t4_tog11", h_tog[11], 0);
    check_eq("t4_tog12", h_tog[12], 1);

    // 5: disable while high, then switch change in IDLE needs no drain
    wait_tog(1'b1, 20, n);
    en = 1'b0; step(1);
    check_eq("t5_tog_off", tog, 0);
    check_eq("t5_busy", busy, 0);
    sw2 = 1'b1; busy_seen = 1'b0;
    record(8);
    check_eq("t5_sel5", h_sel[5], 2'b00);
    check_eq("t5_sel6", h_sel[6], 2'b10);
    check_eq("t5_tog7", h_tog[7], 0);
    check_eq("t5_busy_never", busy_seen, 0);

    // 6: reset during DRAIN
    en = 1'b1; sw1 = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_drain_reached", busy, 1);
    rst = 1'b1; en = 1'b0; step(1);
    check_eq("t6_rst_tog", tog, 0);
    check_eq("t6_rst_sel", sel, 2'b00);
    check_eq("t6_rst_busy", busy, 0);
    step(2);
    rst = 1'b0;
    record(8);
    check_eq("t6_sel5", h_sel[5], 2'b00);
    check_eq("t6_sel6", h_sel[6], 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
